// File: rtl/prbs_pkg.sv
// Shared definitions for the x^4+x^3+1 PRBS checker: the state encoding,
// the generator width and its feedback taps.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  localparam int PRBS_W = 4;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

  // Next bit predicted from the history register (sr[0] is the newest bit).
  function automatic logic prbs_expect(input logic [PRBS_W-1:0] sr);
    return sr[TAP_HI] ^ sr[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module prbs_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  // Count register: reset and clear both zero it, otherwise bump with saturation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS (x^4+x^3+1) checker. Seeds a 4-bit history from the line,
// verifies LOCK_CNT predicted bits, then free-runs a local generator and
// counts mismatches against it until LOSS_CNT consecutive misses drop lock.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W  = $clog2(PRBS_W);
  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  prbs_state_t        state, state_nxt;
  logic [PRBS_W-1:0]  sr, sr_nxt;
  logic [FILL_W-1:0]  fill_cnt, fill_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic               exp_bit;
  logic               mismatch;
  logic               err_inc;
  logic               bit_inc;

  assign exp_bit  = prbs_expect(sr);
  assign mismatch = (din != exp_bit);

  // Next-state logic: all state holds while din_valid is low.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_inc   = 1'b0;
    bit_inc   = 1'b0;
    if (din_valid) begin
      case (state)
        SEED: begin
          sr_nxt = {sr[PRBS_W-2:0], din};
          if (fill_cnt == FILL_W'(PRBS_W - 1)) begin
            // All-zero history is the generator's lockup state; refill instead.
            fill_nxt = '0;
            if (sr_nxt != '0) begin
              state_nxt = VERIFY;
              match_nxt = '0;
            end
          end else begin
            fill_nxt = fill_cnt + FILL_W'(1);
          end
        end
        VERIFY: begin
          sr_nxt = {sr[PRBS_W-2:0], din};
          if (mismatch) begin
            state_nxt = SEED;
            fill_nxt  = '0;
            match_nxt = '0;
          end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
            miss_nxt  = '0;
          end else begin
            match_nxt = match_cnt + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Feed back the prediction, not the line, so a single line error
          // does not corrupt the history and cause follow-on errors.
          sr_nxt  = {sr[PRBS_W-2:0], exp_bit};
          bit_inc = 1'b1;
          if (mismatch) begin
            err_inc = 1'b1;
            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
              state_nxt = SEED;
              fill_nxt  = '0;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: begin
          state_nxt = SEED;
          fill_nxt  = '0;
          match_nxt = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_inc;
    end
  end

  prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (err_clr),
    .count (err_count)
  );

  prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_inc),
    .clr   (err_clr),
    .count (bit_count)
  );

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 8, meaning consecutive matching bits needed to declare lock.
REQ-002 Parameter LOSS_CNT, default 4, meaning consecutive mismatches in LOCKED that drop lock.
REQ-003 Parameter CNT_W, default 16, meaning width of error and bit counters.
REQ-004 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port din, input, 1, received serial PRBS bit.
REQ-008 Port din_valid, input, 1, din is sampled only when high.
REQ-009 Port err_clr, input, 1, synchronous clear of err_count and bit_count.
REQ-010 Port locked, output, 1, high while state is LOCKED.
REQ-011 Port err_pulse, output, 1, one-cycle strobe per mismatched bit in LOCKED.
REQ-012 Port err_count, output, CNT_W, saturating count of mismatches in LOCKED.
REQ-013 Port bit_count, output, CNT_W, saturating count of valid bits checked in LOCKED.

Function
REQ-014 The checker targets the 4-bit PRBS x^4+x^3+1 (period 15): b[n] = b[n-4] XOR b[n-3].
REQ-015 A 4-bit history register sr holds the last four bits, with sr[0] newest; expected bit = sr[3] XOR sr[2].
REQ-016 On each valid bit, sr shifts left: sr <= {sr[2:0], in_bit}.
REQ-017 States are SEED, VERIFY, and LOCKED; din_valid low holds all state, counters, and sr.
REQ-018 SEED: in_bit = din; after 4 valid bits, go to VERIFY, except stay in SEED (refilling) if the new sr is 4'b0000.
REQ-019 VERIFY: in_bit = din; a match increments the match count, and a mismatch returns to SEED with fill and match counts zeroed.
REQ-020 VERIFY -> LOCKED on the LOCK_CNT-th consecutive match; locked rises the cycle after that bit is sampled.
REQ-021 LOCKED: in_bit = expected bit (free-running local generator), so one line error yields exactly one err_pulse.
REQ-022 LOCKED mismatch: assert err_pulse the next cycle, increment err_count, and increment the consecutive-miss count.
REQ-023 LOCKED match: clear the consecutive-miss count; every valid bit in LOCKED increments bit_count.
REQ-024 On the LOSS_CNT-th consecutive miss, go to SEED, drop locked the next cycle, and keep err_count/bit_count (that bit is still counted).
REQ-025 err_count and bit_count saturate at all-ones with no wrap.
REQ-026 err_clr takes priority over a simultaneous increment: both counters become 0 that cycle; state and lock are unaffected.
REQ-027 All outputs are registered; err_pulse and the counters reflect a bit one cycle after it is sampled.

Reset
REQ-028 When rst is high at a clock edge: state = SEED, sr = 0, and all internal counts = 0.
REQ-029 When rst is high at a clock edge: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
REQ-030 Reset mid-operation abandons lock immediately, and the next valid bit is fill bit 1 of SEED.
REQ-031 Reset takes priority over din_valid and err_clr.

Structure
REQ-032 Shared package prbs_pkg holds the state enum (SEED/VERIFY/LOCKED), the PRBS width (4), and the tap positions (3,2).
REQ-033 Sub-module prbs_sat_counter (CNT_W-wide, with inc/clr, clear priority, saturation) is instantiated twice, for err_count and bit_count.

Verification
REQ-034 Clean stream from generator seed 4'b1000, din_valid always high -> locked=1 after 4+8=12 valid bits; err_count stays 0; bit_count increments once per bit.
REQ-035 Once locked, invert one bit -> exactly one err_pulse, err_count=1, and locked stays high.
REQ-036 Once locked, invert 4 consecutive bits -> err_count=4 and locked=0 the cycle after the 4th; clean stream then relocks after 12 bits.
REQ-037 Constant din=0 for 100 valid bits -> never leaves SEED, locked=0, err_count=0.
REQ-038 Force err_count to 0xFFFF with an error-rich stream -> count holds 0xFFFF; err_clr coincident with an error -> err_count=0.
REQ-039 Apply rst for 1 cycle while locked, with din_valid toggling -> all outputs 0 next cycle; relock after 12 valid bits.
